// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants, state encoding and width helper for the UART transmitter
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;
    localparam logic [1:0] PAR_MARK = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_t;

    // Counter width able to hold 0..count-1, never narrower than one bit
    function automatic int cnt_width(input int count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - per-bit cycle counter flagging the last cycle of each serial bit
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int ClocksPerBit = 16
) (
    input  logic Clock,
    input  logic Reset,
    input  logic Restart,
    output logic BitEnd
);

    localparam int CW = cnt_width(ClocksPerBit);
    localparam logic [CW-1:0] LAST_COUNT = CW'(ClocksPerBit - 1);

    logic [CW-1:0] count;

    // Count 0..ClocksPerBit-1; wrapping at the terminal count starts the next bit at zero
    always_ff @(posedge Clock) begin
        if (Reset || Restart || BitEnd) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    assign BitEnd = (count == LAST_COUNT);

endmodule

// File: rtl/uart_tx_engine.sv
// rtl/uart_tx_engine.sv - UART transmit engine with ready/valid input and back-to-back framing
module uart_tx_engine
    import uart_pkg::*;
#(
    parameter int DataLength   = 9,
    parameter int ClocksPerBit = 16
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [DataLength-1:0] Data,
    input  logic                  Valid,
    output logic                  Ready,
    input  logic [1:0]            ParityMode,
    input  logic                  TwoStop,
    output logic                  Tx,
    output logic                  Busy,
    output logic                  FrameDone
);

    localparam int BW = cnt_width(DataLength + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DataLength - 1);

    tx_state_t             state, state_next;
    logic [DataLength-1:0] shreg, shreg_next;
    logic [BW-1:0]         bitcnt, bitcnt_next;
    logic                  second_stop, second_stop_next;
    logic                  has_par_q, par_bit_q, two_stop_q;
    logic                  tx_next;
    logic                  bit_end;
    logic                  last_stop;
    logic                  accept;

    function automatic logic parity_bit(input logic [DataLength-1:0] d, input logic [1:0] mode);
        case (mode)
            PAR_EVEN: return ^d;
            PAR_ODD:  return ~^d;
            PAR_MARK: return 1'b1;
            default:  return 1'b0;
        endcase
    endfunction

    // The baud counter idles at zero so the start bit always gets a full bit time
    uart_baud_tick #(
        .ClocksPerBit(ClocksPerBit)
    ) u_baud (
        .Clock  (Clock),
        .Reset  (Reset),
        .Restart(state == ST_IDLE),
        .BitEnd (bit_end)
    );

    assign last_stop = (state == ST_STOP) && bit_end && (second_stop || !two_stop_q);
    assign Ready     = (state == ST_IDLE) || last_stop;
    assign accept    = Valid && Ready;
    assign FrameDone = last_stop;
    assign Busy      = (state != ST_IDLE);

    // State, line and datapath registers; frame options are frozen at the handshake
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state       <= ST_IDLE;
            Tx          <= 1'b1;
            shreg       <= '0;
            bitcnt      <= '0;
            second_stop <= 1'b0;
            has_par_q   <= 1'b0;
            par_bit_q   <= 1'b0;
            two_stop_q  <= 1'b0;
        end else begin
            state       <= state_next;
            Tx          <= tx_next;
            shreg       <= shreg_next;
            bitcnt      <= bitcnt_next;
            second_stop <= second_stop_next;
            if (accept) begin
                has_par_q  <= (ParityMode != PAR_NONE);
                par_bit_q  <= parity_bit(Data, ParityMode);
                two_stop_q <= TwoStop;
            end
        end
    end

    // Next state plus the next line level, so Tx is registered yet aligned with the state
    always_comb begin
        state_next       = state;
        shreg_next       = shreg;
        bitcnt_next      = bitcnt;
        second_stop_next = 1'b0;
        tx_next          = 1'b1;
        if (accept) begin
            shreg_next = Data;
        end
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_next = ST_START;
                    tx_next    = 1'b0;
                end
            end
            ST_START: begin
                tx_next = 1'b0;
                if (bit_end) begin
                    state_next  = ST_DATA;
                    bitcnt_next = '0;
                    tx_next     = shreg[0];
                end
            end
            ST_DATA: begin
                tx_next = shreg[0];
                if (bit_end) begin
                    if (bitcnt == LAST_BIT) begin
                        if (has_par_q) begin
                            state_next = ST_PARITY;
                            tx_next    = par_bit_q;
                        end else begin
                            state_next = ST_STOP;
                            tx_next    = 1'b1;
                        end
                    end else begin
                        bitcnt_next = bitcnt + BW'(1);
                        shreg_next  = shreg >> 1;
                        tx_next     = shreg_next[0];
                    end
                end
            end
            ST_PARITY: begin
                tx_next = par_bit_q;
                if (bit_end) begin
                    state_next = ST_STOP;
                    tx_next    = 1'b1;
                end
            end
            ST_STOP: begin
                second_stop_next = second_stop;
                if (bit_end) begin
                    if (!last_stop) begin
                        second_stop_next = 1'b1;
                    end else if (accept) begin
                        second_stop_next = 1'b0;
                        state_next       = ST_START;
                        tx_next          = 1'b0;
                    end else begin
                        second_stop_next = 1'b0;
                        state_next       = ST_IDLE;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule
